board_renderer: RTL and testbench

BOARD_RENDERER -- requirements
Module: board_renderer

---
 rtl/board_renderer.sv | 297 +++++++++++++++++++++++++++++
 tb/tb_board_renderer.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/board_renderer.sv
// board_renderer
//
// Scans a Tetris-style playfield and streams it to a VGA adapter, one pixel
// per clock. A frame request taken in IDLE snapshots the 20 visible board
// rows and the four active tetromino cells, so the caller may keep updating
// its game state while the frame is drawn.
//
// Each of the 200 visible cells becomes a 4x4 pixel square. Cell (0,0) is the
// bottom-left cell at x 60..63, y 96..99. Rows grow upwards on screen, so
// higher row numbers get smaller y. Colour priority per cell:
//   active tetromino cell -> 3'b110, settled cell -> 3'b111, empty -> 3'b000.
//
// Optional feature macro: RENDER_BORDER_EN
//   When defined, a BORDER pass follows the cell scan. It plots the 1-pixel
//   rectangle x 59..100, y 19..100 in colour 3'b011: top row, then bottom row,
//   then left column y 20..99, then right column y 20..99 (244 pixels).
//   When undefined, the border state and its logic are not built.
//
// Ports
//   clock_on_board      in   system clock, rising edge
//   resetn              in   synchronous active-low reset
//   start_frame         in   frame request, sampled only in IDLE
//   flat_board[229:0]   in   settled cells, bit row*10+col (rows 20..22 hidden)
//   blockN_x[3:0]       in   active tetromino cell column, 0..9 (N = 1..4)
//   blockN_y[4:0]       in   active tetromino cell row, 0..22 (N = 1..4)
//   vga_x[7:0]          out  pixel column (0 when plot is low)
//   vga_y[6:0]          out  pixel row (0 when plot is low)
//   colour[2:0]         out  pixel colour (0 when plot is low)
//   plot                out  pixel write strobe, one pixel per high cycle
//   busy                out  high from the cycle after accept through DONE
//   frame_done          out  one-cycle pulse in the DONE cycle

module board_renderer (
  input  logic         clock_on_board,
  input  logic         resetn,
  input  logic         start_frame,
  input  logic [229:0] flat_board,
  input  logic [3:0]   block1_x,
  input  logic [3:0]   block2_x,
  input  logic [3:0]   block3_x,
  input  logic [3:0]   block4_x,
  input  logic [4:0]   block1_y,
  input  logic [4:0]   block2_y,
  input  logic [4:0]   block3_y,
  input  logic [4:0]   block4_y,
  output logic [7:0]   vga_x,
  output logic [6:0]   vga_y,
  output logic [2:0]   colour,
  output logic         plot,
  output logic         busy,
  output logic         frame_done
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DRAW   = 2'd1;
`ifdef RENDER_BORDER_EN
  localparam logic [1:0] ST_BORDER = 2'd2;
`endif
  localparam logic [1:0] ST_DONE   = 2'd3;

  localparam logic [2:0] COLOUR_ACTIVE  = 3'b110;
  localparam logic [2:0] COLOUR_SETTLED = 3'b111;
  localparam logic [2:0] COLOUR_EMPTY   = 3'b000;

  localparam logic [3:0] LAST_COL = 4'd9;
  localparam logic [4:0] LAST_ROW = 5'd19;

  // Hidden rows are never drawn; fold them into a sink so they are not
  // reported as dangling inputs.
  logic unused_hidden_rows;
  assign unused_hidden_rows = ^flat_board[229:200];

  // Tetromino coordinates gathered into packed vectors, entry 0 = block1.
  logic [3:0][3:0] block_x_bus;
  logic [3:0][4:0] block_y_bus;
  assign block_x_bus = {block4_x, block3_x, block2_x, block1_x};
  assign block_y_bus = {block4_y, block3_y, block2_y, block1_y};

  // State, scan counters and frame snapshot.
  logic [1:0]       state_reg,  state_next;
  logic [3:0]       col_reg,    col_next;
  logic [4:0]       row_reg,    row_next;
  logic [1:0]       dx_reg,     dx_next;
  logic [1:0]       dy_reg,     dy_next;
  logic [199:0]     board_reg,  board_next;
  logic [3:0][3:0]  bx_reg,     bx_next;
  logic [3:0][4:0]  by_reg,     by_next;
`ifdef RENDER_BORDER_EN
  logic [7:0]       border_idx_reg, border_idx_next;
`endif

  // Last pixel of the cell scan: top-right cell, bottom-right pixel.
  logic draw_last;
  assign draw_last = (row_reg == LAST_ROW) && (col_reg == LAST_COL) &&
                     (dx_reg == 2'd3) && (dy_reg == 2'd3);

  // ------------------------------------------------------------------
  // Next-state logic
  // ------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    col_next   = col_reg;
    row_next   = row_reg;
    dx_next    = dx_reg;
    dy_next    = dy_reg;
    board_next = board_reg;
    bx_next    = bx_reg;
    by_next    = by_reg;
`ifdef RENDER_BORDER_EN
    border_idx_next = border_idx_reg;
`endif

    case (state_reg)
      ST_IDLE: begin
        if (start_frame) begin
          state_next = ST_DRAW;
          board_next = flat_board[199:0];
          bx_next    = block_x_bus;
          by_next    = block_y_bus;
          col_next   = 4'd0;
          row_next   = 5'd0;
          dx_next    = 2'd0;
          dy_next    = 2'd0;
`ifdef RENDER_BORDER_EN
          border_idx_next = 8'd0;
`endif
        end
      end

      ST_DRAW: begin
        // dx and dy are 2 bits wide, so they wrap 3 -> 0 on their own.
        dx_next = dx_reg + 2'd1;
        if (dx_reg == 2'd3) begin
          dy_next = dy_reg + 2'd1;
          if (dy_reg == 2'd3) begin
            if (col_reg == LAST_COL) begin
              col_next = 4'd0;
              row_next = (row_reg == LAST_ROW) ? 5'd0 : row_reg + 5'd1;
            end else begin
              col_next = col_reg + 4'd1;
            end
          end
        end
        if (draw_last) begin
`ifdef RENDER_BORDER_EN
          state_next      = ST_BORDER;
          border_idx_next = 8'd0;
`else
          state_next = ST_DONE;
`endif
        end
      end

`ifdef RENDER_BORDER_EN
      ST_BORDER: begin
        if (border_idx_reg == 8'd243) begin
          state_next      = ST_DONE;
          border_idx_next = 8'd0;
        end else begin
          border_idx_next = border_idx_reg + 8'd1;
        end
      end
`endif

      ST_DONE: begin
        state_next = ST_IDLE;
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // ------------------------------------------------------------------
  // State registers
  // ------------------------------------------------------------------
  always_ff @(posedge clock_on_board) begin
    if (!resetn) begin
      state_reg <= ST_IDLE;
      col_reg   <= 4'd0;
      row_reg   <= 5'd0;
      dx_reg    <= 2'd0;
      dy_reg    <= 2'd0;
      board_reg <= '0;
      bx_reg    <= '0;
      by_reg    <= '0;
`ifdef RENDER_BORDER_EN
      border_idx_reg <= 8'd0;
`endif
    end else begin
      state_reg <= state_next;
      col_reg   <= col_next;
      row_reg   <= row_next;
      dx_reg    <= dx_next;
      dy_reg    <= dy_next;
      board_reg <= board_next;
      bx_reg    <= bx_next;
      by_reg    <= by_next;
`ifdef RENDER_BORDER_EN
      border_idx_reg <= border_idx_next;
`endif
    end
  end

  // ------------------------------------------------------------------
  // Cell-scan pixel datapath
  // ------------------------------------------------------------------
  // 4*col + dx is just {col, dx}; likewise 4*row is {row, 2'b00}.
  logic [7:0] draw_x;
  logic [6:0] draw_y;
  assign draw_x = 8'd60 + {2'b00, col_reg, dx_reg};
  assign draw_y = 7'd96 - {row_reg, 2'b00} + {5'd0, dy_reg};

  logic [7:0] cell_idx;
  assign cell_idx = 8'(row_reg) * 8'd10 + 8'(col_reg);

  // One comparator per tetromino cell. Cells in the hidden rows are
  // excluded explicitly so they can never paint a visible cell.
  logic [3:0] block_hit;
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_block_hit
      assign block_hit[gi] = (bx_reg[gi] == col_reg) &&
                             (by_reg[gi] == row_reg) &&
                             (by_reg[gi] < 5'd20);
    end
  endgenerate

  logic [2:0] draw_colour;
  always_comb begin
    if (|block_hit) begin
      draw_colour = COLOUR_ACTIVE;
    end else if (board_reg[cell_idx]) begin
      draw_colour = COLOUR_SETTLED;
    end else begin
      draw_colour = COLOUR_EMPTY;
    end
  end

`ifdef RENDER_BORDER_EN
  // ------------------------------------------------------------------
  // Border pass: index 0..243 walks top row, bottom row, left, right.
  // ------------------------------------------------------------------
  logic [7:0] border_x;
  logic [6:0] border_y;
  always_comb begin
    if (border_idx_reg < 8'd42) begin
      border_x = 8'd59 + border_idx_reg;
      border_y = 7'd19;
    end else if (border_idx_reg < 8'd84) begin
      border_x = 8'd59 + (border_idx_reg - 8'd42);
      border_y = 7'd100;
    end else if (border_idx_reg < 8'd164) begin
      border_x = 8'd59;
      border_y = 7'd20 + 7'(border_idx_reg - 8'd84);
    end else begin
      border_x = 8'd100;
      border_y = 7'd20 + 7'(border_idx_reg - 8'd164);
    end
  end
`endif

  // ------------------------------------------------------------------
  // Outputs: decoded from registered state so that coordinates, colour
  // and strobe always describe the same pixel; all zero when not plotting.
  // ------------------------------------------------------------------
  always_comb begin
    vga_x  = 8'd0;
    vga_y  = 7'd0;
    colour = 3'd0;
    plot   = 1'b0;
    case (state_reg)
      ST_DRAW: begin
        vga_x  = draw_x;
        vga_y  = draw_y;
        colour = draw_colour;
        plot   = 1'b1;
      end
`ifdef RENDER_BORDER_EN
      ST_BORDER: begin
        vga_x  = border_x;
        vga_y  = border_y;
        colour = 3'b011;
        plot   = 1'b1;
      end
`endif
      default: begin
        plot = 1'b0;
      end
    endcase
  end

  assign busy       = (state_reg != ST_IDLE);
  assign frame_done = (state_reg == ST_DONE);

endmodule

// File: tb/tb_board_renderer.sv
// tb_board_renderer
//
// Self-checking bench for board_renderer. Each frame is compared pixel by
// pixel against a reference that derives the expected image from screen
// geometry: a pixel's cell is recovered from its (x,y) and coloured from the
// snapshot board and tetromino cells. Table vectors add hand-computed probe
// pixels; hand-written sequences cover held start_frame with a mid-frame
// board change and a reset in the middle of a frame.

module tb_board_renderer;

`ifdef RENDER_BORDER_EN
  localparam int NPLOT = 3444;
`else
  localparam int NPLOT = 3200;
`endif

  logic         clock_on_board;
  logic         resetn;
  logic         start_frame;
  logic [229:0] flat_board;
  logic [3:0]   block1_x, block2_x, block3_x, block4_x;
  logic [4:0]   block1_y, block2_y, block3_y, block4_y;
  logic [7:0]   vga_x;
  logic [6:0]   vga_y;
  logic [2:0]   colour;
  logic         plot;
  logic         busy;
  logic         frame_done;

  int checks = 0;
  int errors = 0;

  board_renderer dut (
    .clock_on_board(clock_on_board),
    .resetn        (resetn),
    .start_frame   (start_frame),
    .flat_board    (flat_board),
    .block1_x      (block1_x),
    .block2_x      (block2_x),
    .block3_x      (block3_x),
    .block4_x      (block4_x),
    .block1_y      (block1_y),
    .block2_y      (block2_y),
    .block3_y      (block3_y),
    .block4_y      (block4_y),
    .vga_x         (vga_x),
    .vga_y         (vga_y),
    .colour        (colour),
    .plot          (plot),
    .busy          (busy),
    .frame_done    (frame_done)
  );

  initial clock_on_board = 1'b0;
  always #5 clock_on_board = ~clock_on_board;

  typedef struct {
    logic [229:0] board;
    logic [15:0]  bxs;     // [3:0] = block1 ... [15:12] = block4
    logic [19:0]  bys;     // [4:0] = block1 ... [19:15] = block4
    int           probe_k; // plot index of the probe pixel
    int           px;
    int           py;
    logic [2:0]   pc;
  } vec_t;

  // ---------------- reference model ----------------
  function automatic logic [2:0] model_colour(int x, int y, logic [229:0] b,
                                              logic [15:0] bxs, logic [19:0] bys);
    int c, r;
    c = (x - 60) / 4;
    r = (99 - y) / 4;
    for (int i = 0; i < 4; i++) begin
      if (int'(bxs[i*4 +: 4]) == c && int'(bys[i*5 +: 5]) == r && int'(bys[i*5 +: 5]) < 20)
        return 3'b110;
    end
    if (b[r*10 + c]) return 3'b111;
    return 3'b000;
  endfunction

  function automatic int exp_x(int k);
    int b;
    if (k < 3200) return 60 + 4 * ((k / 16) % 10) + (k % 4);
    b = k - 3200;
    if (b < 42) return 59 + b;
    if (b < 84) return 59 + b - 42;
    if (b < 164) return 59;
    return 100;
  endfunction

  function automatic int exp_y(int k);
    int b;
    if (k < 3200) return 96 - 4 * ((k / 16) / 10) + ((k % 16) / 4);
    b = k - 3200;
    if (b < 42) return 19;
    if (b < 84) return 100;
    if (b < 164) return 20 + b - 84;
    return 20 + b - 164;
  endfunction

  function automatic logic [229:0] rand_board(int density);
    logic [229:0] b;
    for (int i = 0; i < 230; i++) b[i] = ($urandom_range(0, 99) < density);
    return b;
  endfunction

  function automatic logic [15:0] rand_bxs();
    logic [15:0] v;
    for (int i = 0; i < 4; i++) v[i*4 +: 4] = 4'($urandom_range(0, 9));
    return v;
  endfunction

  function automatic logic [19:0] rand_bys();
    logic [19:0] v;
    for (int i = 0; i < 4; i++) v[i*5 +: 5] = 5'($urandom_range(0, 22));
    return v;
  endfunction

  task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  task automatic set_inputs(input logic [229:0] b, input logic [15:0] bxs, input logic [19:0] bys);
    flat_board = b;
    {block4_x, block3_x, block2_x, block1_x} = bxs;
    {block4_y, block3_y, block2_y, block1_y} = bys;
  endtask

  // Starts at a negedge with the DUT in IDLE. Requests a frame, checks all
  // NPLOT pixels, the DONE cycle and the following IDLE cycle, and returns
  // at the negedge of that IDLE cycle.
  task automatic run_frame(input string tag, input logic [229:0] b, input logic [15:0] bxs,
                           input logic [19:0] bys, input bit hold, input int change_at,
                           input logic [229:0] new_b, input int probe_k, input int px,
                           input int py, input logic [2:0] pc);
    int k, ex, ey;
    logic [2:0] ec;
    int coord_bad, col_bad, strobe_bad;
    int f_k, f_ax, f_ay, f_ex, f_ey, c_k, c_act, c_exp, s_k;
    coord_bad = 0; col_bad = 0; strobe_bad = 0;
    f_k = 0; f_ax = 0; f_ay = 0; f_ex = 0; f_ey = 0; c_k = 0; c_act = 0; c_exp = 0; s_k = 0;
    set_inputs(b, bxs, bys);
    start_frame = 1'b1;
    @(posedge clock_on_board);
    #1;
    if (!hold) start_frame = 1'b0;
    for (int n = 1; n <= NPLOT + 2; n++) begin
      @(negedge clock_on_board);
      if (n <= NPLOT) begin
        k  = n - 1;
        ex = exp_x(k);
        ey = exp_y(k);
        ec = (k < 3200) ? model_colour(ex, ey, b, bxs, bys) : 3'b011;
        if (plot !== 1'b1 || busy !== 1'b1 || frame_done !== 1'b0) begin
          if (strobe_bad == 0) s_k = k;
          strobe_bad++;
        end
        if (int'(vga_x) != ex || int'(vga_y) != ey) begin
          if (coord_bad == 0) begin
            f_k = k; f_ax = int'(vga_x); f_ay = int'(vga_y); f_ex = ex; f_ey = ey;
          end
          coord_bad++;
        end
        if (colour !== ec) begin
          if (col_bad == 0) begin
            c_k = k; c_act = int'(colour); c_exp = int'(ec);
          end
          col_bad++;
        end
        if (k == probe_k) begin
          check_val({tag, "_probe_x"}, 32'(vga_x), 32'(px));
          check_val({tag, "_probe_y"}, 32'(vga_y), 32'(py));
          check_val({tag, "_probe_colour"}, 32'(colour), 32'(pc));
        end
      end else if (n == NPLOT + 1) begin
        check_val({tag, "_done_pulse"}, 32'(frame_done), 32'd1);
        check_val({tag, "_done_plot"}, 32'(plot), 32'd0);
        check_val({tag, "_done_busy"}, 32'(busy), 32'd1);
        check_val({tag, "_done_outputs_zero"}, 32'({vga_x, vga_y, colour}), 32'd0);
      end else begin
        check_val({tag, "_idle_busy_done_plot"}, 32'({busy, frame_done, plot}), 32'd0);
      end
      if (n == change_at) flat_board = new_b;
    end
    checks++;
    if (strobe_bad != 0) begin
      errors++;
      $display("FAIL %s_strobe: %0d pixels with plot/busy/frame_done wrong, first at k=%0d (plot=%0d busy=%0d), required plot=1 busy=1 frame_done=0",
               tag, strobe_bad, s_k, plot, busy);
    end
    checks++;
    if (coord_bad != 0) begin
      errors++;
      $display("FAIL %s_coord: %0d bad pixels, first k=%0d got (%0d,%0d) required (%0d,%0d)",
               tag, coord_bad, f_k, f_ax, f_ay, f_ex, f_ey);
    end
    checks++;
    if (col_bad != 0) begin
      errors++;
      $display("FAIL %s_colour: %0d bad pixels, first k=%0d got %0d required %0d",
               tag, col_bad, c_k, c_act, c_exp);
    end
  endtask

  vec_t vecs[8];

  initial begin
    logic [229:0] b, b2, zero_board;
    logic [15:0]  hx;
    logic [19:0]  hy;
    int done_cnt, plot_cnt;

    zero_board = '0;
    hx = 16'h0;
    hy = {4{5'd22}};

    // ---------- vector table ----------
    for (int i = 0; i < 8; i++) begin
      vecs[i].board = '0;
      vecs[i].bxs   = hx;
      vecs[i].bys   = hy;
    end
    vecs[0].probe_k = 0;    vecs[0].px = 60; vecs[0].py = 96; vecs[0].pc = 3'b000;
    vecs[1].probe_k = 3199; vecs[1].px = 99; vecs[1].py = 23; vecs[1].pc = 3'b000;
    vecs[2].board[0] = 1'b1;
    vecs[2].probe_k = 0;    vecs[2].px = 60; vecs[2].py = 96; vecs[2].pc = 3'b111;
    vecs[3].board[0] = 1'b1;
    vecs[3].probe_k = 15;   vecs[3].px = 63; vecs[3].py = 99; vecs[3].pc = 3'b111;
    vecs[4].board[194] = 1'b1;
    vecs[4].bxs[3:0] = 4'd4; vecs[4].bys[4:0] = 5'd19;
    vecs[4].probe_k = 3104; vecs[4].px = 76; vecs[4].py = 20; vecs[4].pc = 3'b110;
    vecs[5].board[194] = 1'b1;
    vecs[5].bxs[3:0] = 4'd4; vecs[5].bys[4:0] = 5'd19;
    vecs[5].probe_k = 3119; vecs[5].px = 79; vecs[5].py = 23; vecs[5].pc = 3'b110;
    vecs[6].board[199] = 1'b1;
    vecs[6].bxs[15:12] = 4'd9; vecs[6].bys[19:15] = 5'd0;
    vecs[6].probe_k = 144;  vecs[6].px = 96; vecs[6].py = 96; vecs[6].pc = 3'b110;
    // Tetromino parked in hidden rows 20/21 above cells that are settled.
    vecs[7].board[10] = 1'b1;
    vecs[7].board[0]  = 1'b1;
    vecs[7].bxs = {4'd3, 4'd2, 4'd1, 4'd0};
    vecs[7].bys = {5'd21, 5'd20, 5'd20, 5'd20};
    vecs[7].probe_k = 160;  vecs[7].px = 60; vecs[7].py = 92; vecs[7].pc = 3'b111;

    // ---------- reset state ----------
    resetn      = 1'b0;
    start_frame = 1'b1;
    set_inputs(zero_board, hx, hy);
    repeat (2) @(posedge clock_on_board);
    @(negedge clock_on_board);
    check_val("reset_plot", 32'(plot), 32'd0);
    check_val("reset_busy", 32'(busy), 32'd0);
    check_val("reset_frame_done", 32'(frame_done), 32'd0);
    check_val("reset_vga_x", 32'(vga_x), 32'd0);
    check_val("reset_vga_y", 32'(vga_y), 32'd0);
    check_val("reset_colour", 32'(colour), 32'd0);
    start_frame = 1'b0;
    resetn      = 1'b1;
    @(negedge clock_on_board);
    check_val("idle_no_request_busy", 32'(busy), 32'd0);

    // ---------- table-driven frames ----------
    for (int i = 0; i < 8; i++) begin
      run_frame($sformatf("vec%0d", i), vecs[i].board, vecs[i].bxs, vecs[i].bys, 1'b0, 0,
                zero_board, vecs[i].probe_k, vecs[i].px, vecs[i].py, vecs[i].pc);
    end

    // ---------- held start_frame, board changed mid-frame ----------
    b  = rand_board(40);
    b2 = ~b;
    run_frame("hold_old_map", b, rand_bxs(), rand_bys(), 1'b1, 500, b2, -1, 0, 0, 3'b000);
    run_frame("hold_new_map", b2, rand_bxs(), rand_bys(), 1'b0, 0, zero_board, -1, 0, 0, 3'b000);

    // ---------- reset in the middle of DRAW ----------
    set_inputs(rand_board(50), rand_bxs(), rand_bys());
    start_frame = 1'b1;
    @(posedge clock_on_board);
    #1 start_frame = 1'b0;
    repeat (1000) @(negedge clock_on_board);
    check_val("midframe_plot_before_reset", 32'(plot), 32'd1);
    resetn = 1'b0;
    @(negedge clock_on_board);
    check_val("midreset_plot", 32'(plot), 32'd0);
    check_val("midreset_busy", 32'(busy), 32'd0);
    check_val("midreset_outputs_zero", 32'({vga_x, vga_y, colour, frame_done}), 32'd0);
    @(negedge clock_on_board);
    resetn = 1'b1;
    done_cnt = 0;
    plot_cnt = 0;
    for (int n = 0; n < 3500; n++) begin
      @(negedge clock_on_board);
      if (frame_done === 1'b1) done_cnt++;
      if (plot === 1'b1) plot_cnt++;
    end
    check_val("abandoned_frame_done_count", 32'(done_cnt), 32'd0);
    check_val("abandoned_frame_plot_count", 32'(plot_cnt), 32'd0);

    // ---------- randomized frames against the model ----------
    for (int i = 0; i < 4; i++) begin
      run_frame($sformatf("rand%0d", i), rand_board(15 + 20 * i), rand_bxs(), rand_bys(),
                1'b0, 0, zero_board, -1, 0, 0, 3'b000);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
